// File: rtl/mure_pkg.sv
// Shared types and widths for the trace connector and encoder front end.
// Holds the itype encoding, the uop/common FIFO entry layouts, the FIFO
// reader state type and the helper that decides whether a uop must be
// merged with a common entry.
package mure_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INST_LEN    = 32;
    localparam int unsigned ITYPE_LEN   = 4;
    localparam int unsigned IRETIRE_LEN = 14;
    localparam int unsigned CAUSE_LEN   = 5;
    localparam int unsigned PRIV_LEN    = 2;

    // Machine privilege; also the privilege assumed out of reset.
    localparam logic [PRIV_LEN-1:0] PRIV_M = 2'b11;

    typedef enum logic [ITYPE_LEN-1:0] {
        STD  = 4'd0,
        EXC  = 4'd1,
        INT  = 4'd2,
        ERET = 4'd3,
        NTB  = 4'd4,
        TB   = 4'd5,
        RES  = 4'd6,
        UIJ  = 4'd8,
        IJ   = 4'd9
    } itype_e;

    typedef struct packed {
        itype_e                 itype;
        logic [INST_LEN-1:0]    iaddr;
        logic [IRETIRE_LEN-1:0] iretire;
        logic                   ilastsize;
    } uop_entry_s;

    typedef struct packed {
        logic [CAUSE_LEN-1:0] cause;
        logic [XLEN-1:0]      tval;
        logic [PRIV_LEN-1:0]  priv;
    } common_entry_s;

    typedef enum logic {
        ACTIVE      = 1'b0,
        WAIT_COMMON = 1'b1
    } reader_state_e;

    // Traps and trap returns carry cause/tval/privilege in the common FIFO.
    function automatic logic needs_common(input itype_e t);
        return (t == EXC) || (t == INT) || (t == ERET);
    endfunction

endpackage

// File: rtl/mure_fifo_reader.sv
// Consumer end of the connector's uop and common trace FIFOs.
// Pops one uop per block and, for traps/trap returns, the matching common
// entry in the same cycle, then presents a registered merged block to the
// encoder over a valid/ready handshake.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   uop_empty_i/entry_i    uop FIFO status and FWFT head
//   uop_pop_o              consume uop head this cycle
//   common_empty_i/entry_i common FIFO status and FWFT head
//   common_pop_o           consume common head this cycle
//   valid_o, ready_i       output block handshake
//   itype_o .. tval_o      merged block fields (cause/tval 0 when no trap)
//   priv_o                 current privilege, sticky between traps
//   err_o                  sticky protocol error (reserved itype or timeout)
module mure_fifo_reader
    import mure_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   uop_empty_i,
    input  uop_entry_s             uop_entry_i,
    output logic                   uop_pop_o,
    input  logic                   common_empty_i,
    input  common_entry_s          common_entry_i,
    output logic                   common_pop_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [ITYPE_LEN-1:0]   itype_o,
    output logic [INST_LEN-1:0]    iaddr_o,
    output logic [IRETIRE_LEN-1:0] iretire_o,
    output logic                   ilastsize_o,
    output logic [CAUSE_LEN-1:0]   cause_o,
    output logic [XLEN-1:0]        tval_o,
    output logic [PRIV_LEN-1:0]    priv_o,
    output logic                   err_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    reader_state_e    state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             slot_free;
    logic             uop_pop, common_pop;
    logic             load, load_common, set_err;

    // The output register can take a new block when it is empty or being
    // drained this cycle, so accept-and-reload happens without a bubble.
    assign slot_free = !valid_o || ready_i;

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        uop_pop     = 1'b0;
        common_pop  = 1'b0;
        load        = 1'b0;
        load_common = 1'b0;
        set_err     = 1'b0;
        unique case (state)
            ACTIVE: begin
                if (!uop_empty_i && slot_free) begin
                    if (uop_entry_i.itype == RES) begin
                        // Reserved itype: discard the entry and flag it.
                        uop_pop = 1'b1;
                        set_err = 1'b1;
                    end else if (needs_common(uop_entry_i.itype)) begin
                        if (!common_empty_i) begin
                            uop_pop     = 1'b1;
                            common_pop  = 1'b1;
                            load        = 1'b1;
                            load_common = 1'b1;
                        end else begin
                            state_next = WAIT_COMMON;
                            cnt_next   = '0;
                        end
                    end else begin
                        uop_pop = 1'b1;
                        load    = 1'b1;
                    end
                end
            end
            WAIT_COMMON: begin
                if (!common_empty_i) begin
                    // Counter freezes once the common entry is present; we
                    // only wait for the output slot from here on.
                    if (slot_free && !uop_empty_i) begin
                        uop_pop     = 1'b1;
                        common_pop  = 1'b1;
                        load        = 1'b1;
                        load_common = 1'b1;
                        state_next  = ACTIVE;
                    end
                end else if (cnt == CNT_LAST) begin
                    // Give up on the common entry: emit the uop without trap
                    // information so the trace keeps moving.
                    if (slot_free && !uop_empty_i) begin
                        uop_pop    = 1'b1;
                        load       = 1'b1;
                        set_err    = 1'b1;
                        state_next = ACTIVE;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = ACTIVE;
        endcase
    end

    // Pops are suppressed while reset is held so a reset mid-wait consumes nothing.
    assign uop_pop_o    = uop_pop && rst_ni;
    assign common_pop_o = common_pop && rst_ni;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ACTIVE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o     <= 1'b0;
            itype_o     <= '0;
            iaddr_o     <= '0;
            iretire_o   <= '0;
            ilastsize_o <= 1'b0;
            cause_o     <= '0;
            tval_o      <= '0;
            priv_o      <= PRIV_M;
            err_o       <= 1'b0;
        end else begin
            if (load) begin
                valid_o     <= 1'b1;
                itype_o     <= uop_entry_i.itype;
                iaddr_o     <= uop_entry_i.iaddr;
                iretire_o   <= uop_entry_i.iretire;
                ilastsize_o <= uop_entry_i.ilastsize;
                cause_o     <= load_common ? common_entry_i.cause : '0;
                tval_o      <= load_common ? common_entry_i.tval  : '0;
                if (load_common) begin
                    priv_o <= common_entry_i.priv;
                end
            end else if (slot_free) begin
                valid_o <= 1'b0;
            end
            if (set_err) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule
